seg_display_scan: RTL and testbench

//  Time-multiplexed driver for the 4-digit common-anode seven-segment display.

---
 rtl/seg_display_scan.sv | 168 ++++++++++++++++
 tb/tb_seg_display_scan.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
// seg_display_scan
//   Time-multiplexed driver for a 4-digit common-anode seven-segment display.
//   Scans one digit per slot of DIV clocks, inserts DEAD_CYC blank cycles at
//   the start of every slot, snapshots all four patterns plus drop_activated
//   once per frame so a frame never tears, and flashes the whole display in
//   BLINK_FRAMES-frame halves while a drop is active. All outputs registered.
//
//   Optional feature: define SEG_DIM_EN to add the dim_level port, which
//   shortens the lit part of each slot to (dim_level+1)/4 of the post-dead span.
//
// Ports
//   clk             in   system clock
//   rst_n           in   asynchronous active-low reset
//   seven_seg1..4   in   7-bit active-high patterns (bit0=a .. bit6=g), 1 = leftmost
//   drop_activated  in   level, 1 = blink the display
//   dim_level       in   2-bit brightness select (SEG_DIM_EN only)
//   an_n            out  active-low anode enables, an_n[3] = leftmost digit
//   seg_n           out  active-low segment cathodes, bit0=a .. bit6=g
//   frame_tick      out  one-cycle pulse at the start of each scan frame
module seg_display_scan #(
    parameter int DIV          = 50000,
    parameter int BLINK_FRAMES = 125,
    parameter int DEAD_CYC     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seven_seg1,
    input  logic [6:0] seven_seg2,
    input  logic [6:0] seven_seg3,
    input  logic [6:0] seven_seg4,
    input  logic       drop_activated,
`ifdef SEG_DIM_EN
    input  logic [1:0] dim_level,
`endif
    output logic [3:0] an_n,
    output logic [6:0] seg_n,
    output logic       frame_tick
);

    localparam int SW = $clog2(DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SW-1:0] SLOT_LAST  = SW'(DIV - 1);
    localparam logic [SW-1:0] DEAD_C     = SW'(DEAD_CYC);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {BL_IDLE, BL_ON, BL_OFF} blink_t;

    logic [SW-1:0] slot_cnt_p0;
    logic [1:0]    digit_p0;
    logic          first_p0;
    blink_t        blink_state_p0, blink_nxt;
    logic [BW-1:0] blink_cnt_p0, blink_cnt_nxt;
    logic [6:0]    snap_seg_p0 [4];
    logic          snap_drop_p0;

    logic [6:0]    in_seg [4];
    logic          slot_wrap, frame_start, snap_load;
    logic [6:0]    pat_cur;
    logic          drop_cur;
    logic          in_window, lit;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;

    always_comb begin
        in_seg[0] = seven_seg1;
        in_seg[1] = seven_seg2;
        in_seg[2] = seven_seg3;
        in_seg[3] = seven_seg4;
    end

    assign slot_wrap   = (slot_cnt_p0 == SLOT_LAST);
    assign frame_start = (slot_cnt_p0 == '0) && (digit_p0 == 2'd0);
    // Capture on the last cycle of digit 3 so the new word is in place for
    // digit 0; also on the very first cycle after reset.
    assign snap_load   = first_p0 || (slot_wrap && (digit_p0 == 2'd3));

    // On the first cycle after reset the snapshot is still empty, so use the
    // live inputs directly; afterwards only the snapshot is ever displayed.
    assign pat_cur  = first_p0 ? in_seg[digit_p0] : snap_seg_p0[digit_p0];
    assign drop_cur = first_p0 ? drop_activated   : snap_drop_p0;

    // Blink FSM: only moves on frame boundaries.
    always_comb begin
        blink_nxt     = blink_state_p0;
        blink_cnt_nxt = blink_cnt_p0;
        if (frame_start) begin
            case (blink_state_p0)
                BL_IDLE: begin
                    blink_cnt_nxt = '0;
                    if (drop_cur) blink_nxt = BL_ON;
                end
                BL_ON, BL_OFF: begin
                    if (!drop_cur) begin
                        blink_nxt     = BL_IDLE;
                        blink_cnt_nxt = '0;
                    end else if (blink_cnt_p0 == BLINK_LAST) begin
                        blink_nxt     = (blink_state_p0 == BL_ON) ? BL_OFF : BL_ON;
                        blink_cnt_nxt = '0;
                    end else begin
                        blink_cnt_nxt = blink_cnt_p0 + 1'b1;
                    end
                end
                default: begin
                    blink_nxt     = BL_IDLE;
                    blink_cnt_nxt = '0;
                end
            endcase
        end
    end

`ifdef SEG_DIM_EN
    localparam int unsigned SPAN = DIV - DEAD_CYC;
    int unsigned on_end;
    always_comb begin
        on_end    = DEAD_CYC + (SPAN * (32'(dim_level) + 32'd1)) / 32'd4;
        in_window = (32'(slot_cnt_p0) < on_end);
    end
`else
    assign in_window = 1'b1;
`endif

    // blink_nxt equals the current state except on the frame's first cycle,
    // where it lets the new blink phase take effect without a one-cycle lag.
    assign lit = (slot_cnt_p0 >= DEAD_C) && in_window && (blink_nxt != BL_OFF);

    always_comb begin
        an_nxt  = 4'b1111;
        seg_nxt = 7'h7F;
        if (lit) begin
            an_nxt[2'd3 - digit_p0] = 1'b0;
            seg_nxt                 = ~pat_cur;
        end
    end

    // Stage p0: scan counters, snapshot, blink state and output pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_p0    <= '0;
            digit_p0       <= 2'd0;
            first_p0       <= 1'b1;
            blink_state_p0 <= BL_IDLE;
            blink_cnt_p0   <= '0;
            snap_drop_p0   <= 1'b0;
            for (int i = 0; i < 4; i++) snap_seg_p0[i] <= 7'h00;
            an_n           <= 4'b1111;
            seg_n          <= 7'h7F;
            frame_tick     <= 1'b0;
        end else begin
            first_p0 <= 1'b0;
            if (slot_wrap) begin
                slot_cnt_p0 <= '0;
                digit_p0    <= digit_p0 + 2'd1;
            end else begin
                slot_cnt_p0 <= slot_cnt_p0 + 1'b1;
            end
            if (snap_load) begin
                for (int i = 0; i < 4; i++) snap_seg_p0[i] <= in_seg[i];
                snap_drop_p0 <= drop_activated;
            end
            blink_state_p0 <= blink_nxt;
            blink_cnt_p0   <= blink_cnt_nxt;
            an_n           <= an_nxt;
            seg_n          <= seg_nxt;
            frame_tick     <= frame_start;
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
module tb_seg_display_scan;

    localparam int DIV   = 8;
    localparam int DEAD  = 2;
    localparam int BF    = 2;
    localparam int FRAME = 4 * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] seven_seg1, seven_seg2, seven_seg3, seven_seg4;
    logic       drop_activated;
    logic [1:0] dim_level;
    logic [3:0] an_n;
    logic [6:0] seg_n;
    logic       frame_tick;

    always #5 clk = ~clk;

    seg_display_scan #(.DIV(DIV), .BLINK_FRAMES(BF), .DEAD_CYC(DEAD)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .seven_seg1(seven_seg1),
        .seven_seg2(seven_seg2),
        .seven_seg3(seven_seg3),
        .seven_seg4(seven_seg4),
        .drop_activated(drop_activated),
`ifdef SEG_DIM_EN
        .dim_level(dim_level),
`endif
        .an_n(an_n),
        .seg_n(seg_n),
        .frame_tick(frame_tick)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: cycle index since reset release, per-frame snapshot,
    // and the length of the current run of frames with drop asserted.
    int              e;
    int              run;
    logic [3:0][6:0] cur_pat, nxt_pat;
    bit              cur_lit, nxt_lit;

    typedef struct {
        logic [3:0][6:0] pat;   // [0] = seven_seg1
        logic [3:0][6:0] exp;   // expected seg_n per digit
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, e, act, req);
        end
    endtask

    function automatic logic [3:0][6:0] live_in();
        logic [3:0][6:0] v;
        v[0] = seven_seg1; v[1] = seven_seg2; v[2] = seven_seg3; v[3] = seven_seg4;
        return v;
    endfunction

    function automatic bit frame_lit(input bit drop);
        run = drop ? run + 1 : 0;
        return (run == 0) || ((((run - 1) / BF) % 2) == 0);
    endfunction

    task automatic set_in(input logic [3:0][6:0] p);
        seven_seg1 = p[0]; seven_seg2 = p[1]; seven_seg3 = p[2]; seven_seg4 = p[3];
    endtask

    // One clock: update the model from the inputs seen at the edge, then
    // compare the registered pins against the model for that cycle.
    task automatic step();
        int  slot, digit;
        bit  lit;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        @(posedge clk);
        if (e == 0) begin
            cur_pat = live_in();
            cur_lit = frame_lit(drop_activated);
        end else if (e % FRAME == 0) begin
            cur_pat = nxt_pat;
            cur_lit = nxt_lit;
        end
        if (e % FRAME == FRAME - 1) begin
            nxt_pat = live_in();
            nxt_lit = frame_lit(drop_activated);
        end
        #1;
        slot    = e % DIV;
        digit   = (e / DIV) % 4;
        lit     = (slot >= DEAD) && cur_lit;
        exp_an  = lit ? (4'hF & ~(4'b1000 >> digit)) : 4'hF;
        exp_seg = lit ? ~cur_pat[digit] : 7'h7F;
        chk("model_an_n", 32'(an_n), 32'(exp_an));
        chk("model_seg_n", 32'(seg_n), 32'(exp_seg));
        chk("model_frame_tick", 32'(frame_tick), 32'((slot == 0) && (digit == 0)));
        e++;
    endtask

    task automatic step_to_frame_end();
        do step(); while ((e - 1) % FRAME != FRAME - 1);
    endtask

    // Step n cycles checking lit cycles against constant expected segments.
    task automatic check_span(input string name, input logic [3:0][6:0] exp, input int n);
        int ee, digit;
        for (int i = 0; i < n; i++) begin
            step();
            ee    = e - 1;
            digit = (ee / DIV) % 4;
            if (ee % DIV >= DEAD) begin
                chk({name, "_seg"}, 32'(seg_n), 32'(exp[digit]));
                chk({name, "_an"}, 32'(an_n), 32'(4'hF & ~(4'b1000 >> digit)));
            end else begin
                chk({name, "_dead_an"}, 32'(an_n), 32'hF);
            end
        end
    endtask

    task automatic lit_frame(input string name, input int exp_lit);
        int cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (an_n != 4'hF) cnt++;
        end
        chk(name, 32'(cnt), 32'(exp_lit));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_an_n", 32'(an_n), 32'hF);
        chk("rst_seg_n", 32'(seg_n), 32'h7F);
        chk("rst_frame_tick", 32'(frame_tick), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_hold_an_n", 32'(an_n), 32'hF);
        #3;
        rst_n = 1'b1;
        e   = 0;
        run = 0;
    endtask

    initial begin
        logic [3:0][6:0] cold, hot, drp, pat;
        cold = {7'h5E, 7'h38, 7'h5C, 7'h39};
        hot  = {7'h78, 7'h5C, 7'h76, 7'h00};
        drp  = {7'h73, 7'h5C, 7'h38, 7'h5E};
        vecs[0] = '{pat: cold, exp: {7'h21, 7'h47, 7'h23, 7'h46}};
        vecs[1] = '{pat: hot,  exp: {7'h07, 7'h23, 7'h09, 7'h7F}};
        vecs[2] = '{pat: {7'h00, 7'h00, 7'h00, 7'h00}, exp: {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
        vecs[3] = '{pat: {7'h7F, 7'h7F, 7'h7F, 7'h7F}, exp: {7'h00, 7'h00, 7'h00, 7'h00}};
        vecs[4] = '{pat: {7'h66, 7'h4F, 7'h5B, 7'h06}, exp: {7'h19, 7'h30, 7'h24, 7'h79}};

        e = 0; run = 0;
        dim_level = 2'd3;
        drop_activated = 1'b0;
        set_in(cold);
        #2;
        do_reset();

        // First cycle: frame_tick, then digit 0 lit after the 2 dead cycles.
        check_span("cold_first", vecs[0].exp, FRAME);

        // Table of patterns, each shown for one whole frame.
        for (int v = 0; v < 5; v++) begin
            set_in(vecs[v].pat);
            step_to_frame_end();
            check_span("vec", vecs[v].exp, FRAME);
        end

        // Change to HOT while digit 2 of a frame is showing: no tearing.
        set_in(cold);
        step_to_frame_end();
        check_span("pre_hot", vecs[0].exp, 2 * DIV);
        set_in(hot);
        check_span("torn_frame", vecs[0].exp, 2 * DIV);
        check_span("hot_frame", vecs[1].exp, FRAME);

        // Blink: 2 frames lit, 2 off, ...; release during an off frame.
        set_in(drp);
        drop_activated = 1'b1;
        lit_frame("blink_arm", 24);
        lit_frame("blink_on1", 24);
        lit_frame("blink_on2", 24);
        lit_frame("blink_off1", 0);
        lit_frame("blink_off2", 0);
        lit_frame("blink_on3", 24);
        lit_frame("blink_on4", 24);
        drop_activated = 1'b0;
        lit_frame("blink_off_release", 0);
        lit_frame("blink_after_release", 24);

        // Randomized traffic against the model.
        for (int i = 0; i < 40 * FRAME; i++) begin
            if ($urandom_range(15) == 0) begin
                pat = live_in();
                pat[$urandom_range(3)] = 7'($urandom);
                set_in(pat);
            end
            if ($urandom_range(47) == 0) drop_activated = ~drop_activated;
            step();
        end

        // Reset in the middle of a frame, then resume.
        repeat ($urandom_range(5, 20)) step();
        do_reset();
        for (int i = 0; i < 3 * FRAME; i++) begin
            if ($urandom_range(31) == 0) set_in({7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom)});
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
